// File: rtl/load_buffer_tracker_pkg.sv
// Shared types for the load buffer tracker.
// slot_t : per-slot bookkeeping {busy, killed, trans_id}
// wb_t   : writeback register contents {valid, trans_id, data, ex}
// The record widths follow the 32-bit FPGA core configuration. The tracker's
// TransIdWidth/DataWidth parameters default to these values and must agree with them.
package load_buffer_tracker_pkg;

  localparam int unsigned CfgTransIdWidth = 2;
  localparam int unsigned CfgDataWidth    = 32;

  typedef struct packed {
    logic                       busy;
    logic                       killed;
    logic [CfgTransIdWidth-1:0] trans_id;
  } slot_t;

  typedef struct packed {
    logic                       valid;
    logic [CfgTransIdWidth-1:0] trans_id;
    logic [CfgDataWidth-1:0]    data;
    logic                       ex;
  } wb_t;

endpackage

// File: rtl/load_buffer_tracker_lzc_free_slot.sv
// Lowest-set-bit finder used to pick the next free load buffer slot.
// free  : one bit per slot, 1 = slot available
// idx   : index of the lowest set bit (0 when none set)
// found : at least one bit of free is set
module lzc_free_slot #(
  parameter int unsigned NrEntries = 2,
  parameter int unsigned IdxWidth  = 1
) (
  input  logic [NrEntries-1:0] free,
  output logic [IdxWidth-1:0]  idx,
  output logic                 found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      if (free[i] && !found) begin
        idx   = IdxWidth'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_buffer_tracker.sv
// Tracks loads outstanding between the load unit and the write-through data cache.
// Ports:
//   clk_i, rst_i (sync, active high), flush_i (kill all pending loads)
//   alloc_valid_i / alloc_ready_o / alloc_trans_id_i / alloc_idx_o : slot allocation
//   resp_valid_i / resp_idx_i / resp_data_i / resp_ex_i            : cache response
//   wb_valid_o / wb_trans_id_o / wb_data_o / wb_ex_o               : registered writeback
//   empty_o / full_o                                               : slot occupancy
module load_buffer_tracker
  import load_buffer_tracker_pkg::*;
#(
  parameter int unsigned NrEntries    = 2,
  parameter int unsigned TransIdWidth = CfgTransIdWidth,
  parameter int unsigned DataWidth    = CfgDataWidth,
  localparam int unsigned IdxWidth    = (NrEntries > 1) ? $clog2(NrEntries) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  input  logic [TransIdWidth-1:0] alloc_trans_id_i,
  output logic [IdxWidth-1:0]     alloc_idx_o,
  input  logic                    resp_valid_i,
  input  logic [IdxWidth-1:0]     resp_idx_i,
  input  logic [DataWidth-1:0]    resp_data_i,
  input  logic                    resp_ex_i,
  output logic                    wb_valid_o,
  output logic [TransIdWidth-1:0] wb_trans_id_o,
  output logic [DataWidth-1:0]    wb_data_o,
  output logic                    wb_ex_o,
  output logic                    empty_o,
  output logic                    full_o
);

  slot_t [NrEntries-1:0] slots_q, slots_d;
  wb_t                   wb_q, wb_d;
  logic [NrEntries-1:0]  busy;
  logic [IdxWidth-1:0]   free_idx;
  logic                  free_found;
  logic                  alloc_fire;

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      busy[i] = slots_q[i].busy;
    end
  end

  lzc_free_slot #(
    .NrEntries (NrEntries),
    .IdxWidth  (IdxWidth)
  ) i_free_slot (
    .free  (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  // Readiness looks only at registered busy bits, so a slot freed by a
  // response this cycle becomes allocatable next cycle.
  assign alloc_ready_o = !flush_i && free_found;
  assign alloc_idx_o   = free_idx;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  assign empty_o = ~|busy;
  assign full_o  = &busy;

  always_comb begin
    slots_d  = slots_q;
    wb_d     = wb_q;
    wb_d.valid = 1'b0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      if (flush_i && slots_q[i].busy) begin
        slots_d[i].killed = 1'b1;
      end
      // Responses to idle slots are protocol violations and are ignored.
      if (resp_valid_i && resp_idx_i == IdxWidth'(i) && slots_q[i].busy) begin
        slots_d[i].busy   = 1'b0;
        slots_d[i].killed = 1'b0;
        if (!slots_q[i].killed && !flush_i) begin
          wb_d = '{valid: 1'b1, trans_id: slots_q[i].trans_id,
                   data: resp_data_i, ex: resp_ex_i};
        end
      end
      // Allocation only targets a free slot, so it never collides with a response.
      if (alloc_fire && free_idx == IdxWidth'(i)) begin
        slots_d[i].busy     = 1'b1;
        slots_d[i].killed   = 1'b0;
        slots_d[i].trans_id = alloc_trans_id_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q <= '0;
      wb_q    <= '0;
    end else begin
      slots_q <= slots_d;
      wb_q    <= wb_d;
    end
  end

  assign wb_valid_o    = wb_q.valid;
  assign wb_trans_id_o = wb_q.trans_id;
  assign wb_data_o     = wb_q.data;
  assign wb_ex_o       = wb_q.ex;

endmodule

// File: tb/tb_load_buffer_tracker.sv
// Self-checking bench for load_buffer_tracker: directed vector table,
// reset-in-flight sequence, then randomized traffic against a reference model.
module tb_load_buffer_tracker;

  localparam int NR = 2;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, alloc_valid_i, alloc_ready_o;
  logic [1:0]  alloc_trans_id_i;
  logic [0:0]  alloc_idx_o;
  logic        resp_valid_i;
  logic [0:0]  resp_idx_i;
  logic [31:0] resp_data_i;
  logic        resp_ex_i;
  logic        wb_valid_o;
  logic [1:0]  wb_trans_id_o;
  logic [31:0] wb_data_o;
  logic        wb_ex_o, empty_o, full_o;

  int total = 0;
  int bad   = 0;
  int stray_count = 0;

  load_buffer_tracker #(.NrEntries(2), .TransIdWidth(2), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_trans_id_i(alloc_trans_id_i), .alloc_idx_o(alloc_idx_o),
    .resp_valid_i(resp_valid_i), .resp_idx_i(resp_idx_i),
    .resp_data_i(resp_data_i), .resp_ex_i(resp_ex_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_data_o(wb_data_o), .wb_ex_o(wb_ex_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  // Reference model: what each slot holds and what writeback is expected.
  logic        m_busy   [NR];
  logic        m_killed [NR];
  logic [1:0]  m_tid    [NR];
  logic        m_wbv;
  logic [1:0]  m_wtid;
  logic [31:0] m_wdata;
  logic        m_wex;
  logic        m_ready, m_empty, m_full;
  logic [0:0]  m_idx;

  task automatic model_comb();
    int first;
    first   = -1;
    m_empty = 1'b1;
    m_full  = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (m_busy[i]) m_empty = 1'b0;
      else begin
        m_full = 1'b0;
        if (first < 0) first = i;
      end
    end
    m_ready = !flush_i && (first >= 0);
    m_idx   = (first < 0) ? 1'b0 : 1'(first);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_busy[i] = 1'b0; m_killed[i] = 1'b0; m_tid[i] = '0;
    end
    m_wbv = 1'b0; m_wtid = '0; m_wdata = '0; m_wex = 1'b0;
  endtask

  task automatic model_edge();
    logic       grant;
    logic [0:0] gidx;
    if (rst_i) begin
      model_reset();
    end else begin
      model_comb();
      grant = alloc_valid_i && m_ready;
      gidx  = m_idx;
      m_wbv = 1'b0;
      if (resp_valid_i) begin
        if (!m_busy[resp_idx_i]) stray_count++;
        else begin
          if (!m_killed[resp_idx_i] && !flush_i) begin
            m_wbv = 1'b1; m_wtid = m_tid[resp_idx_i];
            m_wdata = resp_data_i; m_wex = resp_ex_i;
          end
          m_busy[resp_idx_i]   = 1'b0;
          m_killed[resp_idx_i] = 1'b0;
        end
      end
      if (flush_i)
        for (int i = 0; i < NR; i++) if (m_busy[i]) m_killed[i] = 1'b1;
      if (grant) begin
        m_busy[gidx] = 1'b1; m_killed[gidx] = 1'b0; m_tid[gidx] = alloc_trans_id_i;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic av, input logic [1:0] atid,
                       input logic rv, input logic [0:0] ridx, input logic [31:0] rdata,
                       input logic rex);
    rst_i = rst; flush_i = fl; alloc_valid_i = av; alloc_trans_id_i = atid;
    resp_valid_i = rv; resp_idx_i = ridx; resp_data_i = rdata; resp_ex_i = rex;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic fl, av; logic [1:0] atid; logic rv; logic [0:0] ridx; logic [31:0] rdata; logic rex;
    logic e_ready; logic [0:0] e_idx; logic e_empty, e_full, e_wbv;
    logic [1:0] e_tid; logic [31:0] e_data; logic e_ex;
  } vec_t;

  function automatic vec_t mk(logic fl, logic av, logic [1:0] atid, logic rv, logic [0:0] ridx,
                              logic [31:0] rdata, logic rex, logic er, logic [0:0] ei,
                              logic ee, logic ef, logic ewv, logic [1:0] etid,
                              logic [31:0] edata, logic eex);
    vec_t v;
    v.fl = fl; v.av = av; v.atid = atid; v.rv = rv; v.ridx = ridx; v.rdata = rdata; v.rex = rex;
    v.e_ready = er; v.e_idx = ei; v.e_empty = ee; v.e_full = ef; v.e_wbv = ewv;
    v.e_tid = etid; v.e_data = edata; v.e_ex = eex;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Each row: inputs for one cycle, and outputs expected during that cycle.
    //             fl av tid rv idx data          ex  rdy idx emp ful wbv tid data          ex
    tbl.push_back(mk(0,1,2, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0)); // basic
    tbl.push_back(mk(0,0,0, 1,0,32'hDEADBEEF, 0,  1,1, 0,0, 0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,        0,  1,0, 1,0, 1,2,32'hDEADBEEF, 0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0)); // out of order
    tbl.push_back(mk(0,1,3, 0,0,32'h0,        0,  1,1, 0,0, 0,0,32'h0,        0));
    tbl.push_back(mk(0,1,0, 1,1,32'h11111111, 0,  0,0, 0,1, 0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0, 1,0,32'h22222222, 0,  1,1, 0,0, 1,3,32'h11111111, 0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,        0,  1,0, 1,0, 1,1,32'h22222222, 0));
    tbl.push_back(mk(0,1,2, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0)); // flush kills
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        0,  1,1, 0,0, 0,0,32'h0,        0));
    tbl.push_back(mk(1,1,3, 0,0,32'h0,        0,  0,0, 0,1, 0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0, 1,0,32'h33,       0,  0,0, 0,1, 0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0, 1,1,32'h44,       0,  1,0, 0,0, 0,0,32'h0,        0));
    tbl.push_back(mk(1,1,3, 0,0,32'h0,        0,  0,0, 1,0, 0,0,32'h0,        0)); // no alloc in flush
    tbl.push_back(mk(0,0,0, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0));
    tbl.push_back(mk(0,1,0, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0)); // free-next-cycle
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        0,  1,1, 0,0, 0,0,32'h0,        0));
    tbl.push_back(mk(0,1,2, 1,0,32'h55,       0,  0,0, 0,1, 0,0,32'h0,        0));
    tbl.push_back(mk(0,1,2, 0,0,32'h0,        0,  1,0, 0,0, 1,0,32'h55,       0));
    tbl.push_back(mk(0,0,0, 1,1,32'h66,       1,  0,0, 0,1, 0,0,32'h0,        0)); // fault + overlap
    tbl.push_back(mk(0,1,3, 1,0,32'h77,       0,  1,1, 0,0, 1,1,32'h66,       1));
    tbl.push_back(mk(0,0,0, 1,1,32'h88,       1,  1,0, 0,0, 1,2,32'h77,       0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,        0,  1,0, 1,0, 1,3,32'h88,       1));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0));
    tbl.push_back(mk(0,1,1, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0)); // resp during flush
    tbl.push_back(mk(1,0,0, 1,0,32'h99,       0,  0,0, 0,0, 0,0,32'h0,        0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0));
    tbl.push_back(mk(0,1,2, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0)); // wb survives flush
    tbl.push_back(mk(0,0,0, 1,0,32'hAA,       0,  1,1, 0,0, 0,0,32'h0,        0));
    tbl.push_back(mk(1,0,0, 0,0,32'h0,        0,  0,0, 1,0, 1,2,32'hAA,       0));
    tbl.push_back(mk(0,0,0, 0,0,32'h0,        0,  1,0, 1,0, 0,0,32'h0,        0));

    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_empty", 32'(empty_o), 1);
    chk("reset_full", 32'(full_o), 0);
    chk("reset_ready", 32'(alloc_ready_o), 1);
    chk("reset_wbv", 32'(wb_valid_o), 0);
    chk("reset_wbtid", 32'(wb_trans_id_o), 0);
    chk("reset_wbdata", wb_data_o, 0);
    chk("reset_wbex", 32'(wb_ex_o), 0);

    foreach (tbl[n]) begin
      drive(0, tbl[n].fl, tbl[n].av, tbl[n].atid, tbl[n].rv, tbl[n].ridx, tbl[n].rdata, tbl[n].rex);
      chk($sformatf("v%0d_ready", n), 32'(alloc_ready_o), 32'(tbl[n].e_ready));
      if (tbl[n].e_ready) chk($sformatf("v%0d_idx", n), 32'(alloc_idx_o), 32'(tbl[n].e_idx));
      chk($sformatf("v%0d_empty", n), 32'(empty_o), 32'(tbl[n].e_empty));
      chk($sformatf("v%0d_full", n), 32'(full_o), 32'(tbl[n].e_full));
      chk($sformatf("v%0d_wbv", n), 32'(wb_valid_o), 32'(tbl[n].e_wbv));
      if (tbl[n].e_wbv) begin
        chk($sformatf("v%0d_wbtid", n), 32'(wb_trans_id_o), 32'(tbl[n].e_tid));
        chk($sformatf("v%0d_wbdata", n), wb_data_o, tbl[n].e_data);
        chk($sformatf("v%0d_wbex", n), 32'(wb_ex_o), 32'(tbl[n].e_ex));
      end
      tick();
    end

    // Reset with both slots busy and a response in flight, then a stray response.
    drive(0, 0, 1, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 2, 0, 0, 0, 0);
    chk("rst_seq_full_before", 32'(full_o), 0);
    tick();
    drive(1, 0, 0, 0, 1, 0, 32'hBB, 0);
    chk("rst_seq_full", 32'(full_o), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_seq_empty", 32'(empty_o), 1);
    chk("rst_seq_wbv", 32'(wb_valid_o), 0);
    chk("rst_seq_ready", 32'(alloc_ready_o), 1);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'hCC, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stray_wbv", 32'(wb_valid_o), 0);
    chk("stray_empty", 32'(empty_o), 1);
    chk("stray_flagged", 32'(stray_count), 1);
    tick();

    // Randomized traffic: responses only target slots the model holds busy.
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst, r_fl, r_av, r_rv;
      logic [0:0]  r_idx;
      int          busy_list[$];
      busy_list.delete();
      for (int i = 0; i < NR; i++) if (m_busy[i]) busy_list.push_back(i);
      r_rst = ($urandom_range(0, 99) < 2);
      r_fl  = ($urandom_range(0, 99) < 10);
      r_av  = ($urandom_range(0, 1) == 1);
      r_rv  = (busy_list.size() > 0) && ($urandom_range(0, 1) == 1);
      r_idx = (busy_list.size() > 0) ? 1'(busy_list[$urandom_range(0, busy_list.size() - 1)]) : 1'b0;
      drive(r_rst, r_fl, r_av, 2'($urandom_range(0, 3)), r_rv, r_idx, $urandom, 1'($urandom_range(0, 1)));
      model_comb();
      chk("rnd_ready", 32'(alloc_ready_o), 32'(m_ready));
      if (m_ready) chk("rnd_idx", 32'(alloc_idx_o), 32'(m_idx));
      chk("rnd_empty", 32'(empty_o), 32'(m_empty));
      chk("rnd_full", 32'(full_o), 32'(m_full));
      chk("rnd_wbv", 32'(wb_valid_o), 32'(m_wbv));
      if (m_wbv) begin
        chk("rnd_wbtid", 32'(wb_trans_id_o), 32'(m_wtid));
        chk("rnd_wbdata", wb_data_o, m_wdata);
        chk("rnd_wbex", 32'(wb_ex_o), 32'(m_wex));
      end
      tick();
    end
    chk("rnd_no_stray", 32'(stray_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_buffer_tracker.md
Name: load_buffer_tracker

Overview:
- Tracks loads outstanding between the load unit and the write-through data cache on the 32-bit FPGA core configuration.
- Sizing is taken from the core config: NrLoadBufEntries = 2, scoreboard depth = 4, one load pipe register.
- On issue, it allocates a buffer index that travels with the cache request as its tag. When the cache responds with that index, it recovers the scoreboard transaction ID and presents the result, after one registered pipe stage, to the writeback port.
- On pipeline flush, pending loads are killed: their responses are still absorbed, but they are never written back.

Parameters:
- NrEntries, 2, number of outstanding loads tracked (1..8).
- TransIdWidth, 2, scoreboard transaction ID width (clog2 of NrScoreboardEntries = 4).
- DataWidth, 32, load data width (XLEN).
- IdxWidth, derived: NrEntries > 1 ? clog2(NrEntries) : 1. Not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  kill all pending loads.
- alloc_valid_i  in  1  load unit requests a slot.
- alloc_ready_o  out  1  a free slot exists and flush_i is low.
- alloc_trans_id_i  in  TransIdWidth  scoreboard ID of the load.
- alloc_idx_o  out  IdxWidth  slot granted; valid when alloc_valid_i && alloc_ready_o.
- resp_valid_i  in  1  cache load response.
- resp_idx_i  in  IdxWidth  slot tag returned by the cache.
- resp_data_i  in  DataWidth  load data.
- resp_ex_i  in  1  response carries an access fault.
- wb_valid_o  out  1  writeback valid; no backpressure.
- wb_trans_id_o  out  TransIdWidth  scoreboard ID.
- wb_data_o  out  DataWidth  load data.
- wb_ex_o  out  1  fault flag.
- empty_o  out  1  no slot busy (used by fence/flush logic).
- full_o  out  1  all slots busy.

Behaviour:
Per-slot state:
- Each slot holds busy, killed and trans_id.
- Reset: all busy = 0 and killed = 0; wb_valid_o = 0; wb_trans_id_o, wb_data_o and wb_ex_o = 0; empty_o = 1; full_o = 0.

Allocation:
- alloc_ready_o = !flush_i && (some slot has busy = 0), evaluated on registered state only.
- alloc_idx_o is the lowest-index free slot.
- On a handshake, at the next edge: busy = 1, killed = 0, trans_id = alloc_trans_id_i.
- A slot freed by a response in cycle t is not allocatable until cycle t+1.

Response:
- A response frees slot resp_idx_i (busy = 0) at the next edge.
- If the slot is not killed and flush_i is low, the writeback register loads {1, trans_id, resp_data_i, resp_ex_i}. wb_valid_o therefore rises exactly 1 cycle after resp_valid_i.
- Otherwise wb_valid_o = 0 next cycle and the data is dropped.
- wb_valid_o is a 1-cycle pulse per response; consecutive responses give back-to-back pulses.
- A response to a non-busy slot is a protocol violation. It is ignored (no state change, no writeback) and has a bench assertion.

Flush:
- flush_i at edge t sets killed = 1 on every busy slot. Busy is kept until that slot's response arrives.
- A response in the same cycle as flush_i is dropped.
- A writeback already registered (wb_valid_o high during flush) is still presented; the scoreboard discards it.
- No allocation occurs while flush_i is high.

Simultaneous allocation and response:
- When allocation and response hit different slots in the same cycle, both take effect.
- They cannot hit the same slot, by construction.

Status flags:
- empty_o = no slot busy; full_o = all slots busy. Both are registered-state functions, including killed slots.

Reset mid-operation:
- rst_i clears all slots and the writeback register at the next edge.
- A response arriving in the reset cycle is lost.

Decomposition:
- Shared package: the slot record typedef {busy, killed, trans_id} and the writeback record typedef {valid, trans_id, data, ex}.
- One sub-module is natural: lzc_free_slot, a lowest-set-bit finder over the inverted busy vector, producing index and found flag. The existing common-cells lzc may be used in its place.

Test Plan:
1. Reset, then alloc with trans_id = 2 → alloc_idx_o = 0, empty_o = 0. Response on idx 0 with data 0xDEADBEEF → wb_valid_o one cycle later with trans_id = 2, data = 0xDEADBEEF, and empty_o = 1.
2. Alloc trans_ids 1 and 3 → slots 0 and 1, full_o = 1, alloc_ready_o = 0. Response on idx 1 first → writeback trans_id = 3. Then idx 0 → writeback trans_id = 1 (out-of-order completion).
3. Two loads pending, flush_i pulsed → both slots killed and alloc_ready_o = 0 during the flush. Responses on idx 0 and 1 then produce no wb_valid_o, and empty_o returns to 1.
4. Full buffer, response on idx 0 in the same cycle as alloc_valid_i → no grant that cycle; grant of idx 0 the next cycle.
5. One slot busy, alloc plus response on the other slot in the same cycle → both take effect. Also: resp_ex_i = 1 on a live slot → wb_ex_o = 1 with the matching trans_id.
6. rst_i asserted with 2 slots busy and a response in flight → next cycle empty_o = 1, wb_valid_o = 0, and a later stray response is ignored (assertion fires).
